// File: rtl/pmod_acl2_spi_responder.sv
// SPI responder that emulates a Pmod ACL2 (ADXL362-style) register file for loopback builds.
// SCK/CSn/COPI are oversampled in the system clock domain.
module pmod_acl2_spi_responder #(
  parameter logic [7:0] parm_devid_ad  = 8'hAD,
  parameter logic [7:0] parm_devid_mst = 8'h1D,
  parameter logic [7:0] parm_partid    = 8'hF2,
  parameter logic [7:0] parm_revid     = 8'h01
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic        i_sck,
  input  logic        i_csn,
  input  logic        i_copi,
  output logic        o_cipo,
  output logic        o_cipo_oe,
  input  logic        i_sample_valid,
  input  logic [47:0] i_sample_xyz,
  output logic        o_wr_valid,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_ADDR = 2'd2, ST_DATA = 2'd3} state_t;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  function automatic logic is_writable(input logic [5:0] a);
    if (a < 6'h04) begin
      is_writable = 1'b0;
    end else if (a == 6'h0B) begin
      is_writable = 1'b0;
    end else if ((a >= 6'h0E) && (a <= 6'h13)) begin
      is_writable = 1'b0;
    end else begin
      is_writable = 1'b1;
    end
  endfunction

  logic [1:0]  sck_sync_r, csn_sync_r, copi_sync_r, rst_vld_r;
  logic        sck_d_r, busy_r, armed_r;
  state_t      state_r, state_nxt_s;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  rx_r;
  logic [7:0]  cmd_r, shift_r, rd_data_s, rx_byte_s;
  logic [5:0]  addr_r;
  logic        load_pend_r, pend_valid_r;
  logic [47:0] pend_r, commit_data_s;
  logic [7:0]  reg_r [0:63];
  logic        sck_rise_s, sck_fall_s, csn_fall_s, csn_rise_s, byte_done_s;
  logic        addr_done_s, data_done_s, wr_fire_s, rd_mode_s, rd_clear_s, commit_s;

  // Synchronizers, edge history and post-reset arming (a CSn already low at release is ignored)
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      sck_sync_r  <= 2'b00;
      csn_sync_r  <= 2'b11;
      copi_sync_r <= 2'b00;
      rst_vld_r   <= 2'b00;
      sck_d_r     <= 1'b0;
      busy_r      <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[0], i_sck};
      csn_sync_r  <= {csn_sync_r[0], i_csn};
      copi_sync_r <= {copi_sync_r[0], i_copi};
      rst_vld_r   <= {rst_vld_r[0], 1'b1};
      sck_d_r     <= sck_sync_r[1];
      busy_r      <= ~csn_sync_r[1];
      armed_r     <= armed_r | (rst_vld_r[1] & csn_sync_r[1]);
    end
  end

  assign sck_rise_s  = sck_sync_r[1] & ~sck_d_r;
  assign sck_fall_s  = ~sck_sync_r[1] & sck_d_r;
  assign csn_fall_s  = ~busy_r & ~csn_sync_r[1] & armed_r;
  assign csn_rise_s  = busy_r & csn_sync_r[1];
  assign byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7);
  assign rx_byte_s   = {rx_r, copi_sync_r[1]};
  assign rd_data_s   = reg_r[addr_r];
  assign o_busy      = busy_r;

  // FSM state register
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (csn_rise_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (csn_fall_s)  state_nxt_s = ST_CMD;  else state_nxt_s = ST_IDLE;
        ST_CMD:  if (byte_done_s) state_nxt_s = ST_ADDR; else state_nxt_s = ST_CMD;
        ST_ADDR: if (byte_done_s) state_nxt_s = ST_DATA; else state_nxt_s = ST_ADDR;
        ST_DATA: state_nxt_s = ST_DATA;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode
  always_comb begin
    addr_done_s = 1'b0;
    data_done_s = 1'b0;
    rd_mode_s   = (cmd_r == CMD_RD);
    case (state_r)
      ST_ADDR: addr_done_s = byte_done_s;
      ST_DATA: data_done_s = byte_done_s;
      default: begin
        addr_done_s = 1'b0;
        data_done_s = 1'b0;
      end
    endcase
    wr_fire_s  = data_done_s & (cmd_r == CMD_WR) & is_writable(addr_r);
    rd_clear_s = sck_fall_s & load_pend_r & (addr_r == 6'h0E);
  end

  // Bit counter, receive shifter, command/address capture and CIPO shifter
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      bit_cnt_r   <= 3'd0;
      rx_r        <= 7'd0;
      cmd_r       <= 8'h00;
      addr_r      <= 6'h00;
      load_pend_r <= 1'b0;
      shift_r     <= 8'h00;
      o_cipo      <= 1'b0;
    end else begin
      if (csn_fall_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sck_rise_s && (state_r != ST_IDLE)) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        rx_r      <= rx_byte_s[6:0];
      end
      if ((state_r == ST_CMD) && byte_done_s) begin
        cmd_r <= rx_byte_s;
      end
      if (addr_done_s) begin
        addr_r <= rx_byte_s[5:0];
      end else if (data_done_s) begin
        addr_r <= addr_r + 6'd1;
      end
      if (state_r == ST_IDLE) begin
        load_pend_r <= 1'b0;
      end else if ((addr_done_s || data_done_s) && rd_mode_s) begin
        load_pend_r <= 1'b1;
      end else if (sck_fall_s) begin
        load_pend_r <= 1'b0;
      end
      if (state_r == ST_IDLE) begin
        o_cipo  <= 1'b0;
        shift_r <= 8'h00;
      end else if (sck_fall_s && load_pend_r) begin
        o_cipo  <= rd_data_s[7];
        shift_r <= {rd_data_s[6:0], 1'b0};
      end else if (sck_fall_s && (state_r == ST_DATA) && rd_mode_s) begin
        o_cipo  <= shift_r[7];
        shift_r <= {shift_r[6:0], 1'b0};
      end
    end
  end

  // Sample commit selection: a strobe at the CSn-rise cycle is newer than the pending copy
  always_comb begin
    commit_s      = 1'b0;
    commit_data_s = i_sample_xyz;
    if (csn_rise_s) begin
      if (i_sample_valid) begin
        commit_s = 1'b1;
      end else if (pend_valid_r) begin
        commit_s      = 1'b1;
        commit_data_s = pend_r;
      end else begin
        commit_s = 1'b0;
      end
    end else if (i_sample_valid && !busy_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Pending sample buffer held while a transaction is in progress
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      pend_valid_r <= 1'b0;
      pend_r       <= 48'h0;
    end else if (csn_rise_s) begin
      pend_valid_r <= 1'b0;
    end else if (i_sample_valid && busy_r) begin
      pend_valid_r <= 1'b1;
      pend_r       <= i_sample_xyz;
    end
  end

  // Register file: SPI writes, sample commits and DATA_READY management
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      for (int i = 0; i < 64; i++) begin
        reg_r[i[5:0]] <= 8'h00;
      end
      reg_r[6'h00] <= parm_devid_ad;
      reg_r[6'h01] <= parm_devid_mst;
      reg_r[6'h02] <= parm_partid;
      reg_r[6'h03] <= parm_revid;
    end else begin
      if (wr_fire_s) begin
        reg_r[addr_r] <= rx_byte_s;
      end
      if (commit_s) begin
        reg_r[6'h0E]    <= commit_data_s[7:0];
        reg_r[6'h0F]    <= commit_data_s[15:8];
        reg_r[6'h10]    <= commit_data_s[23:16];
        reg_r[6'h11]    <= commit_data_s[31:24];
        reg_r[6'h12]    <= commit_data_s[39:32];
        reg_r[6'h13]    <= commit_data_s[47:40];
        reg_r[6'h0B][0] <= 1'b1;
      end else if (rd_clear_s) begin
        reg_r[6'h0B][0] <= 1'b0;
      end
    end
  end

  // Registered write-report and output-enable outputs
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      o_wr_valid <= 1'b0;
      o_wr_addr  <= 6'h00;
      o_wr_data  <= 8'h00;
      o_cipo_oe  <= 1'b0;
    end else begin
      o_wr_valid <= wr_fire_s;
      o_cipo_oe  <= ~csn_sync_r[1];
      if (wr_fire_s) begin
        o_wr_addr <= addr_r;
        o_wr_data <= rx_byte_s;
      end
    end
  end

endmodule

// File: tb/tb_pmod_acl2_spi_responder.sv
// Scoreboard bench for pmod_acl2_spi_responder: stimulus pushes expected CIPO bytes and
// register writes; independent monitors pop and compare as the DUT presents them.
module tb_pmod_acl2_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sck = 1'b0;
  logic        csn = 1'b1;
  logic        copi = 1'b0;
  logic        cipo, cipo_oe;
  logic        sample_valid = 1'b0;
  logic [47:0] sample_xyz = 48'h0;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;

  logic [8:0]  exp_rd[$];
  logic [13:0] exp_wr[$];
  int          mon_cnt = 0;
  logic [7:0]  mon_byte = 8'h00;

  pmod_acl2_spi_responder dut (
    .i_clk_20mhz   (clk),
    .i_rstn_20mhz  (rstn),
    .i_sck         (sck),
    .i_csn         (csn),
    .i_copi        (copi),
    .o_cipo        (cipo),
    .o_cipo_oe     (cipo_oe),
    .i_sample_valid(sample_valid),
    .i_sample_xyz  (sample_xyz),
    .o_wr_valid    (wr_valid),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      copi = b[7-i];
      clks(HALF);
      sck = 1'b1;
      clks(HALF);
      sck = 1'b0;
    end
  endtask

  // expect a checked CIPO byte
  task automatic rd_byte(input logic [7:0] tx, input logic [7:0] rx);
    exp_rd.push_back({1'b1, rx});
    send_bits(tx, 8);
  endtask

  // CIPO not checked for this byte
  task automatic dc_byte(input logic [7:0] tx);
    exp_rd.push_back(9'h000);
    send_bits(tx, 8);
  endtask

  task automatic cs_low();
    csn = 1'b0;
    clks(6);
  endtask

  task automatic cs_high();
    clks(4);
    csn = 1'b1;
    clks(10);
  endtask

  task automatic pulse_sample(input logic [47:0] v);
    sample_xyz   = v;
    sample_valid = 1'b1;
    clks(1);
    sample_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cipo"}, {31'd0, cipo}, 32'd0);
    check({tag, "_cipo_oe"}, {31'd0, cipo_oe}, 32'd0);
    check({tag, "_wr_valid"}, {31'd0, wr_valid}, 32'd0);
    check({tag, "_wr_addr"}, {26'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic rd_compare(input logic [7:0] got);
    logic [8:0] e;
    if (exp_rd.size() == 0) begin
      check("rd_unexpected_byte", {24'd0, got}, 32'hFFFF_FFFF);
    end else begin
      e = exp_rd.pop_front();
      if (e[8]) check("rd_byte", {24'd0, got}, {24'd0, e[7:0]});
    end
  endtask

  // CIPO monitor: samples on SCK rise, discards partial bytes on CSn rise or reset
  always @(posedge sck or posedge csn or negedge rstn) begin
    if (!rstn || csn) begin
      mon_cnt <= 0;
    end else begin
      if (mon_cnt == 7) begin
        rd_compare({mon_byte[6:0], cipo});
        mon_cnt <= 0;
      end else begin
        mon_cnt <= mon_cnt + 1;
      end
      mon_byte <= {mon_byte[6:0], cipo};
    end
  end

  // Write-report monitor
  always @(negedge clk) begin
    if (wr_valid) begin
      if (exp_wr.size() == 0) check("wr_unexpected", {18'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else check("wr_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, exp_wr.pop_front()});
    end
  end

  initial begin
    clks(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    clks(10);

    // Read ID burst
    cs_low();
    check("busy_in_cs", {31'd0, busy}, 32'd1);
    check("oe_in_cs", {31'd0, cipo_oe}, 32'd1);
    rd_byte(8'h0B, 8'h00);
    rd_byte(8'h00, 8'h00);
    rd_byte(8'h00, 8'hAD);
    rd_byte(8'h00, 8'h1D);
    rd_byte(8'h00, 8'hF2);
    rd_byte(8'h00, 8'h01);
    cs_high();
    check("oe_after_cs", {31'd0, cipo_oe}, 32'd0);
    check("busy_after_cs", {31'd0, busy}, 32'd0);

    // Write burst then read back
    exp_wr.push_back({6'h2C, 8'h13});
    exp_wr.push_back({6'h2D, 8'h02});
    cs_low();
    rd_byte(8'h0A, 8'h00); rd_byte(8'h2C, 8'h00); dc_byte(8'h13); dc_byte(8'h02);
    cs_high();
    check("wr_addr_held", {26'd0, wr_addr}, 32'h2D);
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h2C, 8'h00); rd_byte(8'h00, 8'h13); rd_byte(8'h00, 8'h02);
    cs_high();

    // Wrap into read-only space
    exp_wr.push_back({6'h3F, 8'h55});
    cs_low();
    rd_byte(8'h0A, 8'h00); rd_byte(8'h3F, 8'h00); dc_byte(8'h55); dc_byte(8'h77);
    cs_high();
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h3F, 8'h00); rd_byte(8'h00, 8'h55); rd_byte(8'h00, 8'hAD);
    cs_high();

    // Samples during a transaction stay pending; newest wins
    cs_low();
    pulse_sample(48'hFFFF_FFFF_FFFF);
    rd_byte(8'h0B, 8'h00);
    pulse_sample(48'h0605_0403_0201);
    rd_byte(8'h0E, 8'h00); rd_byte(8'h00, 8'h00);
    cs_high();
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h0B, 8'h00);
    rd_byte(8'h00, 8'h01); rd_byte(8'h00, 8'h00); rd_byte(8'h00, 8'h00);
    rd_byte(8'h00, 8'h01); rd_byte(8'h00, 8'h02);
    cs_high();
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h0B, 8'h00); rd_byte(8'h00, 8'h00);
    cs_high();

    // Partial byte and unknown command
    cs_low();
    rd_byte(8'h0A, 8'h00); rd_byte(8'h20, 8'h00);
    send_bits(8'hC3, 5);
    cs_high();
    cs_low();
    rd_byte(8'h7F, 8'h00); rd_byte(8'h20, 8'h00); rd_byte(8'hAA, 8'h00);
    cs_high();
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h20, 8'h00); rd_byte(8'h00, 8'h00);
    cs_high();

    // Reset in the middle of a read, CSn held low across release
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h00, 8'h00); rd_byte(8'h00, 8'hAD);
    send_bits(8'h00, 4);
    rstn = 1'b0;
    clks(2);
    check_reset_outputs("midreset");
    rstn = 1'b1;
    clks(8);
    rd_byte(8'h0B, 8'h00); rd_byte(8'h00, 8'h00); rd_byte(8'h00, 8'h00);
    cs_high();
    cs_low();
    rd_byte(8'h0B, 8'h00); rd_byte(8'h00, 8'h00); rd_byte(8'h00, 8'hAD);
    cs_high();

    clks(10);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
